// File: rtl/arith_unit_seq.sv
// arith_unit_seq: registered arithmetic unit with a valid/ready command port
// and a valid/ready result port. Simple ops finish on the accepting edge;
// multiply and divide iterate one bit per cycle for WIDTH cycles.
module arith_unit_seq #(
    parameter  int WIDTH = 8,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             div_zero,
    output logic             op_err
);

    // Simple ops are evaluated two bits wider than the operands so that the
    // carry out of a+b, b<<1 and a+1 stays a positive value, while the only
    // possible negative result (b-1 with b==0) sign-extends to all ones.
    localparam int EW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       OP_MUL   = 4'b1000;
    localparam logic [3:0]       OP_DIV   = 4'b1001;

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg;

    logic [RES_W-1:0] mul_acc_reg;
    logic [RES_W-1:0] mul_cand_reg;
    logic [WIDTH-1:0] mul_plier_reg;

    logic [WIDTH-1:0] div_rem_reg;
    logic [WIDTH-1:0] div_quo_reg;
    logic [WIDTH-1:0] div_dsr_reg;

    logic             out_valid_reg;
    logic [RES_W-1:0] result_reg;
    logic             div_zero_reg;
    logic             op_err_reg;

    logic [EW-1:0]    ext_a;
    logic [EW-1:0]    ext_b;
    logic [EW-1:0]    sc_val;
    logic [RES_W-1:0] ld_res;
    logic             ld_dz;
    logic             ld_oe;

    logic             accept;
    logic             go_busy;
    logic             busy_last;
    logic             load_now;

    logic [RES_W-1:0] mul_acc_next;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;
    logic [RES_W-1:0] fin_res;

    assign ext_a = EW'(a);
    assign ext_b = EW'(b);

    // Handshake: only an idle unit whose result slot is free (or being drained) takes a command.
    assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign go_busy   = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    assign busy_last = (state_reg == BUSY) && (cnt_reg == CNT_LAST);
    assign load_now  = (accept && !go_busy) || busy_last;

    // Single-cycle arithmetic on the extended operands.
    always_comb begin
        sc_val = '0;
        case (op[2:0])
            3'd0:    sc_val = ext_a;
            3'd1:    sc_val = ext_a + ext_b;
            3'd2:    sc_val = ext_b - EW'(1);
            3'd3:    sc_val = (a >= b) ? (ext_a - ext_b) : (ext_b - ext_a);
            3'd4:    sc_val = ext_b << 1;
            3'd5:    sc_val = ext_a >> 1;
            3'd6:    sc_val = ext_a + EW'(1);
            3'd7:    sc_val = ext_b;
            default: sc_val = '0;
        endcase
    end

    // Value and flags loaded on the accepting edge for commands that do not iterate.
    always_comb begin
        ld_res = '0;
        ld_dz  = 1'b0;
        ld_oe  = 1'b0;
        if (!op[3]) begin
            ld_res = RES_W'($signed(sc_val));
        end else if (op == OP_DIV) begin
            // Only reached with b==0: quotient saturates, remainder is the dividend.
            ld_res = {a, {WIDTH{1'b1}}};
            ld_dz  = 1'b1;
        end else if (op != OP_MUL) begin
            ld_oe  = 1'b1;
        end
    end

    // One shift-add / restoring-subtract step per BUSY cycle.
    always_comb begin
        mul_acc_next = mul_acc_reg + (mul_plier_reg[0] ? mul_cand_reg : '0);
        div_trial    = {div_rem_reg, div_quo_reg[WIDTH-1]};
        div_ge       = (div_trial >= {1'b0, div_dsr_reg});
        // When the trial fits the divisor the difference is below the divisor, so WIDTH bits suffice.
        div_rem_next = div_ge ? (div_trial[WIDTH-1:0] - div_dsr_reg) : div_trial[WIDTH-1:0];
        div_quo_next = {div_quo_reg[WIDTH-2:0], div_ge};
        fin_res      = is_div_reg ? {div_rem_next, div_quo_next} : mul_acc_next;
    end

    // Control FSM, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_div_reg    <= 1'b0;
            mul_acc_reg   <= '0;
            mul_cand_reg  <= '0;
            mul_plier_reg <= '0;
            div_rem_reg   <= '0;
            div_quo_reg   <= '0;
            div_dsr_reg   <= '0;
            result_reg    <= '0;
            div_zero_reg  <= 1'b0;
            op_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go_busy) begin
                        state_reg     <= BUSY;
                        cnt_reg       <= '0;
                        is_div_reg    <= (op == OP_DIV);
                        mul_acc_reg   <= '0;
                        mul_cand_reg  <= RES_W'(a);
                        mul_plier_reg <= b;
                        div_rem_reg   <= '0;
                        div_quo_reg   <= a;
                        div_dsr_reg   <= b;
                    end else if (accept) begin
                        result_reg    <= ld_res;
                        div_zero_reg  <= ld_dz;
                        op_err_reg    <= ld_oe;
                    end
                end
                BUSY: begin
                    cnt_reg       <= cnt_reg + CNT_W'(1);
                    mul_acc_reg   <= mul_acc_next;
                    mul_cand_reg  <= mul_cand_reg << 1;
                    mul_plier_reg <= mul_plier_reg >> 1;
                    div_rem_reg   <= div_rem_next;
                    div_quo_reg   <= div_quo_next;
                    if (busy_last) begin
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                        result_reg   <= fin_res;
                        div_zero_reg <= 1'b0;
                        op_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Result-valid flag: set on any load, cleared when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
        end else if (load_now) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign div_zero  = div_zero_reg;
    assign op_err    = op_err_reg;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq (WIDTH=8): a transaction-level model predicts
// in_ready, out_valid, result and flags every cycle; directed vectors carry
// hand-computed literal expectations as well.
module tb_arith_unit_seq;

    localparam int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [3:0]       op = '0;
    logic             in_ready;
    logic             out_valid;
    logic [RES_W-1:0] result;
    logic             div_zero;
    logic             op_err;

    int errors = 0;
    int checks = 0;

    arith_unit_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [RES_W-1:0] model_value(input logic [3:0] o,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        longint ia;
        longint ib;
        longint v;
        ia = longint'(x);
        ib = longint'(y);
        case (o)
            4'd0: v = ia;
            4'd1: v = ia + ib;
            4'd2: v = ib - 1;
            4'd3: v = (ia > ib) ? ia - ib : ib - ia;
            4'd4: v = ib * 2;
            4'd5: v = ia / 2;
            4'd6: v = ia + 1;
            4'd7: v = ib;
            4'd8: v = ia * ib;
            4'd9: v = (ib == 0) ? ((ia << WIDTH) + ((longint'(1) << WIDTH) - 1))
                                : (((ia % ib) << WIDTH) + (ia / ib));
            default: v = 0;
        endcase
        return v[RES_W-1:0];
    endfunction

    function automatic logic model_multi(input logic [3:0] o, input logic [WIDTH-1:0] y);
        return (o == 4'd8) || (o == 4'd9 && y != 0);
    endfunction

    logic             m_busy = 1'b0;
    int               m_left = 0;
    logic             m_valid = 1'b0;
    logic [RES_W-1:0] m_res = '0;
    logic [RES_W-1:0] m_pend = '0;
    logic             m_dz = 1'b0;
    logic             m_oe = 1'b0;

    function automatic logic model_ready();
        return !m_busy && (!m_valid || out_ready);
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_dz    <= 1'b0;
            m_oe    <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_res   <= m_pend;
                m_dz    <= 1'b0;
                m_oe    <= 1'b0;
                m_valid <= 1'b1;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end else if (in_valid && model_ready()) begin
            if (model_multi(op, b)) begin
                m_busy <= 1'b1;
                m_left <= WIDTH;
                m_pend <= model_value(op, a, b);
                if (out_ready) m_valid <= 1'b0;
            end else begin
                m_res   <= model_value(op, a, b);
                m_dz    <= (op == 4'd9);
                m_oe    <= (op >= 4'd10);
                m_valid <= 1'b1;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, model_ready());
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("result", result, m_res);
                check("div_zero", div_zero, m_dz);
                check("op_err", op_err, m_oe);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present a command from posedge+1 and hold it until accepted; returns edges waited.
    task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        check("issue_accept", acc, 1'b1);
    endtask

    // Wait for out_valid; lat counts negedges without a result, irlow those with in_ready=0.
    task automatic wait_result(input string name, input logic [RES_W-1:0] er,
                               input logic edz, input logic eoe,
                               output int lat, output int irlow);
        lat = 0;
        irlow = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (!in_ready) irlow++;
            lat++;
            @(negedge clk);
        end
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_result"}, result, er);
        check({name, "_dz"}, div_zero, edz);
        check({name, "_oe"}, op_err, eoe);
        $display("txn %s: result=0x%04h div_zero=%0d op_err=%0d latency=%0d", name, result, div_zero, op_err, lat);
    endtask

    logic [3:0]       bb_op  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [WIDTH-1:0] bb_a   [8] = '{8'h5A, 8'h80, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'h00};
    logic [WIDTH-1:0] bb_b   [8] = '{8'h11, 8'h80, 8'h10, 8'h30, 8'hFF, 8'h00, 8'h00, 8'hC3};
    logic [RES_W-1:0] bb_exp [8] = '{16'h005A, 16'h0100, 16'h000F, 16'h0020,
                                     16'h01FE, 16'h007F, 16'h0100, 16'h00C3};

    initial begin
        int w;
        int lat;
        int irl;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_op_err", op_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // First edge after release accepts; add with carry out
        align();
        rst_n = 1'b1;
        issue(4'd1, 8'd255, 8'd1, w);
        check("first_edge_accept", w, 1);
        wait_result("add_255_1", 16'h0100, 1'b0, 1'b0, lat, irl);
        check("add_latency", lat, 0);

        // Back-to-back single-cycle commands, one per cycle
        align();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = bb_op[i];
            a = bb_a[i];
            b = bb_b[i];
            @(negedge clk);
            check("b2b_in_ready", in_ready, 1'b1);
            if (i > 0) begin
                check("b2b_result", result, bb_exp[i-1]);
                $display("txn b2b[%0d]: op=%0d result=0x%04h", i - 1, bb_op[i-1], result);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_result", result, bb_exp[7]);
        $display("txn b2b[7]: op=%0d result=0x%04h", bb_op[7], result);

        // b-1 underflow, then |a-b|
        align();
        issue(4'd2, 8'd0, 8'd0, w);
        wait_result("dec_b0", 16'hFFFF, 1'b0, 1'b0, lat, irl);
        align();
        issue(4'd3, 8'd3, 8'd10, w);
        wait_result("absdiff", 16'h0007, 1'b0, 1'b0, lat, irl);

        // Multiply: 8 busy cycles, result on the 9th edge
        align();
        issue(4'd8, 8'd200, 8'd150, w);
        wait_result("mul_200_150", 16'h7530, 1'b0, 1'b0, lat, irl);
        check("mul_latency", lat, 8);
        check("mul_ready_low", irl, 8);
        align();
        issue(4'd8, 8'd255, 8'd255, w);
        wait_result("mul_255_255", 16'hFE01, 1'b0, 1'b0, lat, irl);

        // Divide, then divide by zero (single cycle)
        align();
        issue(4'd9, 8'd100, 8'd7, w);
        wait_result("div_100_7", 16'h020E, 1'b0, 1'b0, lat, irl);
        check("div_latency", lat, 8);
        align();
        issue(4'd9, 8'd255, 8'd1, w);
        wait_result("div_255_1", 16'h00FF, 1'b0, 1'b0, lat, irl);
        align();
        issue(4'd9, 8'd5, 8'd0, w);
        wait_result("div_zero", 16'h05FF, 1'b1, 1'b0, lat, irl);
        check("divz_latency", lat, 0);

        // Backpressure: result and flags hold while out_ready=0
        align();
        out_ready = 1'b0;
        issue(4'd6, 8'd9, 8'd0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", result, 16'h000A);
            check("hold_dz", div_zero, 1'b0);
            check("hold_in_ready", in_ready, 1'b0);
        end
        $display("txn hold: result=0x%04h held 5 cycles", result);
        align();
        out_ready = 1'b1;
        issue(4'd7, 8'd0, 8'h33, w);
        check("release_accept_edges", w, 1);
        wait_result("after_hold", 16'h0033, 1'b0, 1'b0, lat, irl);

        // Reset in the middle of a multiply
        align();
        issue(4'd8, 8'd200, 8'd150, w);
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_result", result, 16'h0000);
        align();
        rst_n = 1'b1;
        irl = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) irl++;
        end
        check("abort_no_result", irl, 0);
        $display("txn abort: no result delivered after reset");

        // Illegal opcodes
        align();
        issue(4'd12, 8'h12, 8'h34, w);
        wait_result("illegal_c", 16'h0000, 1'b0, 1'b1, lat, irl);
        align();
        issue(4'd15, 8'hFF, 8'hFF, w);
        wait_result("illegal_f", 16'h0000, 1'b0, 1'b1, lat, irl);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
